// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter sharing one ID-less AXI slave port between NUM_M masters.
// The write and read paths have separate grant FSMs and separate rotation pointers.
module axi_rr_arbiter #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                              aclk,
    input  logic                              areset,
    // master-side write address / data / response
    input  logic [NUM_M*ADDR_WIDTH-1:0]       m_awaddr,
    input  logic [NUM_M*8-1:0]                m_awlen,
    input  logic [NUM_M-1:0]                  m_awvalid,
    output logic [NUM_M-1:0]                  m_awready,
    input  logic [NUM_M*DATA_WIDTH-1:0]       m_wdata,
    input  logic [NUM_M*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [NUM_M-1:0]                  m_wlast,
    input  logic [NUM_M*USER_WIDTH-1:0]       m_wuser,
    input  logic [NUM_M-1:0]                  m_wvalid,
    output logic [NUM_M-1:0]                  m_wready,
    output logic [NUM_M*2-1:0]                m_bresp,
    output logic [NUM_M*USER_WIDTH-1:0]       m_buser,
    output logic [NUM_M-1:0]                  m_bvalid,
    input  logic [NUM_M-1:0]                  m_bready,
    // master-side read address / data
    input  logic [NUM_M*ADDR_WIDTH-1:0]       m_araddr,
    input  logic [NUM_M*8-1:0]                m_arlen,
    input  logic [NUM_M-1:0]                  m_arvalid,
    output logic [NUM_M-1:0]                  m_arready,
    output logic [NUM_M*DATA_WIDTH-1:0]       m_rdata,
    output logic [NUM_M-1:0]                  m_rlast,
    output logic [NUM_M*USER_WIDTH-1:0]       m_ruser,
    output logic [NUM_M*2-1:0]                m_rresp,
    output logic [NUM_M-1:0]                  m_rvalid,
    input  logic [NUM_M-1:0]                  m_rready,
    // slave side
    output logic [ADDR_WIDTH-1:0]             s_awaddr,
    output logic [7:0]                        s_awlen,
    output logic                              s_awvalid,
    input  logic                              s_awready,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [DATA_WIDTH/8-1:0]           s_wstrb,
    output logic                              s_wlast,
    output logic [USER_WIDTH-1:0]             s_wuser,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    input  logic [1:0]                        s_bresp,
    input  logic [USER_WIDTH-1:0]             s_buser,
    input  logic                              s_bvalid,
    output logic                              s_bready,
    output logic [ADDR_WIDTH-1:0]             s_araddr,
    output logic [7:0]                        s_arlen,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_rlast,
    input  logic [USER_WIDTH-1:0]             s_ruser,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rvalid,
    output logic                              s_rready
);

    localparam int IDX_W  = $clog2(NUM_M);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic [IDX_W-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d;
    logic [IDX_W-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d;

    // First requester at or after ptr, searching cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        int               idx;
        sel = ptr;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_M;
            if (req[idx]) sel = IDX_W'(idx);
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_M - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wgnt_q    <= '0;
            wptr_q    <= '0;
            rgnt_q    <= '0;
            rptr_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wgnt_q    <= wgnt_d;
            wptr_q    <= wptr_d;
            rgnt_q    <= rgnt_d;
            rptr_q    <= rptr_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        wptr_d    = wptr_q;
        case (w_state_q)
            W_IDLE: if (|m_awvalid) begin
                wgnt_d    = rr_pick(m_awvalid, wptr_q);
                w_state_d = W_ADDR;
            end
            W_ADDR: if (m_awvalid[wgnt_q] && s_awready) w_state_d = W_DATA;
            W_DATA: if (m_wvalid[wgnt_q] && s_wready && m_wlast[wgnt_q]) w_state_d = W_RESP;
            W_RESP: if (s_bvalid && m_bready[wgnt_q]) begin
                w_state_d = W_IDLE;
                wptr_d    = rr_next(wgnt_q);
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        rptr_d    = rptr_q;
        case (r_state_q)
            R_IDLE: if (|m_arvalid) begin
                rgnt_d    = rr_pick(m_arvalid, rptr_q);
                r_state_d = R_ADDR;
            end
            R_ADDR: if (m_arvalid[rgnt_q] && s_arready) r_state_d = R_DATA;
            R_DATA: if (s_rvalid && m_rready[rgnt_q] && s_rlast) begin
                r_state_d = R_IDLE;
                rptr_d    = rr_next(rgnt_q);
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write-path muxing; everything is held at zero while reset is asserted.
    always_comb begin
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awvalid = 1'b0;
        m_awready = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wuser   = '0;
        s_wvalid  = 1'b0;
        m_wready  = '0;
        m_bresp   = '0;
        m_buser   = '0;
        m_bvalid  = '0;
        s_bready  = 1'b0;
        if (!areset) begin
            case (w_state_q)
                W_ADDR: begin
                    s_awaddr          = m_awaddr[int'(wgnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
                    s_awlen           = m_awlen[int'(wgnt_q)*8 +: 8];
                    s_awvalid         = m_awvalid[wgnt_q];
                    m_awready[wgnt_q] = s_awready;
                end
                W_DATA: begin
                    s_wdata          = m_wdata[int'(wgnt_q)*DATA_WIDTH +: DATA_WIDTH];
                    s_wstrb          = m_wstrb[int'(wgnt_q)*STRB_W +: STRB_W];
                    s_wlast          = m_wlast[wgnt_q];
                    s_wuser          = m_wuser[int'(wgnt_q)*USER_WIDTH +: USER_WIDTH];
                    s_wvalid         = m_wvalid[wgnt_q];
                    m_wready[wgnt_q] = s_wready;
                end
                W_RESP: begin
                    m_bresp[int'(wgnt_q)*2 +: 2]                   = s_bresp;
                    m_buser[int'(wgnt_q)*USER_WIDTH +: USER_WIDTH] = s_buser;
                    m_bvalid[wgnt_q]                               = s_bvalid;
                    s_bready                                       = m_bready[wgnt_q];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = 1'b0;
        m_arready = '0;
        m_rdata   = '0;
        m_rlast   = '0;
        m_ruser   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        if (!areset) begin
            case (r_state_q)
                R_ADDR: begin
                    s_araddr          = m_araddr[int'(rgnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
                    s_arlen           = m_arlen[int'(rgnt_q)*8 +: 8];
                    s_arvalid         = m_arvalid[rgnt_q];
                    m_arready[rgnt_q] = s_arready;
                end
                R_DATA: begin
                    m_rdata[int'(rgnt_q)*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                    m_rlast[rgnt_q]                                = s_rlast;
                    m_ruser[int'(rgnt_q)*USER_WIDTH +: USER_WIDTH] = s_ruser;
                    m_rresp[int'(rgnt_q)*2 +: 2]                   = s_rresp;
                    m_rvalid[rgnt_q]                               = s_rvalid;
                    s_rready                                       = m_rready[rgnt_q];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed testbench for axi_rr_arbiter with two masters; the bench drives the slave side by hand.
// Inputs change and outputs are checked 1-2 ns after each rising edge.
module tb_axi_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int UW = 1;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NM*AW-1:0]  m_awaddr, m_araddr;
    logic [NM*8-1:0]   m_awlen, m_arlen;
    logic [NM-1:0]     m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [NM*DW-1:0]  m_wdata, m_rdata;
    logic [NM*DW/8-1:0] m_wstrb;
    logic [NM*UW-1:0]  m_wuser, m_buser, m_ruser;
    logic [NM*2-1:0]   m_bresp, m_rresp;
    logic [NM-1:0]     m_bvalid, m_bready, m_arvalid, m_arready;
    logic [NM-1:0]     m_rlast, m_rvalid, m_rready;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [7:0]        s_awlen, s_arlen;
    logic              s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [DW/8-1:0]   s_wstrb;
    logic [UW-1:0]     s_wuser, s_buser, s_ruser;
    logic [1:0]        s_bresp, s_rresp;
    logic              s_bvalid, s_bready, s_arvalid, s_arready;
    logic              s_rlast, s_rvalid, s_rready;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 aclk = ~aclk;

    axi_rr_arbiter #(.NUM_M(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .aclk(aclk), .areset(areset),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_ruser(m_ruser), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_buser(s_buser), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_ruser(s_ruser), .s_rresp(s_rresp),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        m_awaddr = '0; m_awlen = '0; m_awvalid = '0;
        m_wdata = '0; m_wstrb = '1; m_wlast = '0; m_wuser = '0; m_wvalid = '0;
        m_bready = '0;
        m_araddr = '0; m_arlen = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0;
        s_bresp = 2'b00; s_buser = '0; s_bvalid = 1'b0;
        s_arready = 1'b0;
        s_rdata = '0; s_rlast = 1'b0; s_ruser = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset = 1'b1;
        m_awvalid = 2'b11; m_arvalid = 2'b11; m_wvalid = 2'b11;
        s_awready = 1'b1; s_arready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_rvalid = 1'b1;
        m_bready = 2'b11; m_rready = 2'b11;
        step(); step(); step();
        n_cmp++; if ({s_awvalid, s_wvalid, s_arvalid} !== 3'b000) begin n_mis++; $display("FAIL reset_s_valid: got %b want 000", {s_awvalid, s_wvalid, s_arvalid}); end
        n_cmp++; if ({s_bready, s_rready} !== 2'b00) begin n_mis++; $display("FAIL reset_s_ready: got %b want 00", {s_bready, s_rready}); end
        n_cmp++; if ({m_awready, m_wready, m_arready} !== 6'b0) begin n_mis++; $display("FAIL reset_m_ready: got %b want 000000", {m_awready, m_wready, m_arready}); end
        n_cmp++; if ({m_bvalid, m_rvalid} !== 4'b0) begin n_mis++; $display("FAIL reset_m_valid: got %b want 0000", {m_bvalid, m_rvalid}); end
        n_cmp++; if ({s_awaddr, s_araddr, s_wdata} !== '0) begin n_mis++; $display("FAIL reset_data_zero: got %h %h %h want 0", s_awaddr, s_araddr, s_wdata); end
        clear_inputs();
        areset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        do_reset();
        m_awaddr[AW-1:0] = 10'h040; m_awlen[7:0] = 8'd3; m_awvalid = 2'b01; s_awready = 1'b1;
        #1;
        n_cmp++; if (s_awvalid !== 1'b0) begin n_mis++; $display("FAIL sw_aw_latency0: got %b want 0", s_awvalid); end
        step();
        n_cmp++; if ({s_awvalid, s_awaddr, s_awlen} !== {1'b1, 10'h040, 8'd3}) begin n_mis++; $display("FAIL sw_aw_fwd: got %b %h %0d want 1 040 3", s_awvalid, s_awaddr, s_awlen); end
        n_cmp++; if (m_awready !== 2'b01) begin n_mis++; $display("FAIL sw_awready: got %b want 01", m_awready); end
        step();
        m_awvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b1; m_wvalid = 2'b01;
        for (int b = 0; b < 4; b++) begin
            m_wdata[DW-1:0] = 32'(b);
            m_wlast[0] = (b == 3);
            #1;
            n_cmp++; if ({s_wvalid, s_wdata, s_wlast, m_wready} !== {1'b1, 32'(b), (b == 3), 2'b01}) begin n_mis++; $display("FAIL sw_beat%0d: got v=%b d=%h l=%b rdy=%b", b, s_wvalid, s_wdata, s_wlast, m_wready); end
            step();
        end
        m_wvalid = 2'b00; m_wlast = '0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b01;
        #1;
        n_cmp++; if ({m_bvalid, m_bresp[1:0], s_bready} !== {2'b01, 2'b00, 1'b1}) begin n_mis++; $display("FAIL sw_bresp: got bv=%b br=%b sbr=%b want 01 00 1", m_bvalid, m_bresp[1:0], s_bready); end
        step();
        n_cmp++; if (m_bvalid !== 2'b00) begin n_mis++; $display("FAIL sw_b_done: got %b want 00", m_bvalid); end
        s_bvalid = 1'b0; m_bready = 2'b00;
        // wptr should now be 1: a simultaneous request goes to m1
        m_awvalid = 2'b11; s_awready = 1'b1;
        step();
        n_cmp++; if (m_awready !== 2'b10) begin n_mis++; $display("FAIL sw_wptr1: got %b want 10", m_awready); end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp;
        do_reset();
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_wlast = 2'b11; m_bready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_cmp++; if (m_awready !== 2'b00) begin n_mis++; $display("FAIL rr%0d_idle: got %b want 00", i, m_awready); end
            step();
            n_cmp++; if (m_awready !== exp) begin n_mis++; $display("FAIL rr%0d_aw: got %b want %b", i, m_awready, exp); end
            n_cmp++; if ({s_wvalid, m_wready, m_bvalid} !== 5'b0) begin n_mis++; $display("FAIL rr%0d_w_early: got %b want 00000", i, {s_wvalid, m_wready, m_bvalid}); end
            step();
            n_cmp++; if (m_wready !== exp) begin n_mis++; $display("FAIL rr%0d_w: got %b want %b", i, m_wready, exp); end
            step();
            n_cmp++; if ({m_bvalid, s_bready} !== {exp, 1'b1}) begin n_mis++; $display("FAIL rr%0d_b: got %b want %b1", i, {m_bvalid, s_bready}, exp); end
            step();
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        m_araddr[2*AW-1:AW] = 10'h100; m_arlen[15:8] = 8'd7; m_arvalid = 2'b10; s_arready = 1'b1;
        m_awlen[7:0] = 8'd1; m_awvalid = 2'b01; s_awready = 1'b1;
        step();
        n_cmp++; if ({m_arready, s_araddr, s_arlen} !== {2'b10, 10'h100, 8'd7}) begin n_mis++; $display("FAIL cc_ar: got %b %h %0d want 10 100 7", m_arready, s_araddr, s_arlen); end
        n_cmp++; if (m_awready !== 2'b01) begin n_mis++; $display("FAIL cc_aw: got %b want 01", m_awready); end
        step();
        m_arvalid = '0; m_awvalid = '0;
        m_rready = 2'b11; s_rvalid = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            s_rdata = 32'h0A0 + 32'(i);
            s_rlast = (i == 7);
            m_wvalid = (i < 2) ? 2'b01 : 2'b00;
            m_wdata[DW-1:0] = 32'h55 + 32'(i);
            m_wlast[0] = (i == 1);
            #1;
            n_cmp++; if ({m_rvalid, m_rdata[2*DW-1:DW], m_rlast} !== {2'b10, 32'h0A0 + 32'(i), (i == 7), 1'b0}) begin n_mis++; $display("FAIL cc_r%0d: got v=%b d=%h l=%b", i, m_rvalid, m_rdata[2*DW-1:DW], m_rlast); end
            if (i < 2) begin
                n_cmp++; if ({m_wready, s_wdata} !== {2'b01, 32'h55 + 32'(i)}) begin n_mis++; $display("FAIL cc_w%0d: got rdy=%b d=%h", i, m_wready, s_wdata); end
            end else if (i == 2) begin
                n_cmp++; if (m_bvalid !== 2'b01) begin n_mis++; $display("FAIL cc_b: got %b want 01", m_bvalid); end
            end else if (i == 3) begin
                n_cmp++; if (m_bvalid !== 2'b00) begin n_mis++; $display("FAIL cc_b_done: got %b want 00", m_bvalid); end
            end
            step();
        end
        n_cmp++; if ({m_rvalid, s_rready} !== 3'b000) begin n_mis++; $display("FAIL cc_r_done: got %b want 000", {m_rvalid, s_rready}); end
    endtask

    task automatic test_grant_hold();
        do_reset();
        m_awvalid = 2'b01; s_awready = 1'b1; s_wready = 1'b1;
        step();
        n_cmp++; if (m_awready !== 2'b01) begin n_mis++; $display("FAIL gh_aw0: got %b want 01", m_awready); end
        step();
        m_awvalid = 2'b10; m_wvalid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            m_wlast[0] = (i == 2);
            #1;
            n_cmp++; if (m_awready !== 2'b00) begin n_mis++; $display("FAIL gh_wdata%0d: got %b want 00", i, m_awready); end
            step();
        end
        m_wvalid = 2'b00; m_wlast = '0; s_bvalid = 1'b1; m_bready = 2'b00;
        #1;
        n_cmp++; if ({m_awready, m_bvalid} !== 4'b0001) begin n_mis++; $display("FAIL gh_resp_wait: got %b want 0001", {m_awready, m_bvalid}); end
        step();
        m_bready = 2'b01;
        #1;
        n_cmp++; if (m_awready !== 2'b00) begin n_mis++; $display("FAIL gh_resp_hs: got %b want 00", m_awready); end
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
        n_cmp++; if (m_awready !== 2'b00) begin n_mis++; $display("FAIL gh_idle: got %b want 00", m_awready); end
        step();
        n_cmp++; if (m_awready !== 2'b10) begin n_mis++; $display("FAIL gh_aw1: got %b want 10", m_awready); end
    endtask

    task automatic test_back_to_back();
        int d;
        logic rdy;
        do_reset();
        m_awlen[7:0] = 8'd3; m_awvalid = 2'b01; s_awready = 1'b1;
        step();
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b01;
        d = 0;
        for (int c = 0; c < 7; c++) begin
            rdy = (c % 2 == 0);
            s_wready = rdy;
            m_wdata[DW-1:0] = 32'h10 + 32'(d);
            m_wlast[0] = (d == 3);
            #1;
            n_cmp++; if ({s_wvalid, s_wdata, m_wready} !== {1'b1, 32'h10 + 32'(d), 1'b0, rdy}) begin n_mis++; $display("FAIL bp_c%0d: got v=%b d=%h rdy=%b want d=%h rdy=%b", c, s_wvalid, s_wdata, m_wready, 32'h10 + 32'(d), rdy); end
            step();
            if (rdy) d++;
        end
        m_wvalid = 2'b00; m_wlast = '0; s_wready = 1'b0; s_bvalid = 1'b1; m_bready = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if ({m_bvalid, s_bready, s_wvalid} !== 4'b0100) begin n_mis++; $display("FAIL bp_bhold%0d: got %b want 0100", c, {m_bvalid, s_bready, s_wvalid}); end
            step();
        end
        m_bready = 2'b01;
        #1;
        n_cmp++; if (s_bready !== 1'b1) begin n_mis++; $display("FAIL bp_bready: got %b want 1", s_bready); end
        step();
        n_cmp++; if (m_bvalid !== 2'b00) begin n_mis++; $display("FAIL bp_b_done: got %b want 00", m_bvalid); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        // short m0 read first so rptr moves to 1
        m_arvalid = 2'b01; s_arready = 1'b1;
        step();
        step();
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b01;
        #1;
        n_cmp++; if (m_rvalid !== 2'b01) begin n_mis++; $display("FAIL rm_first_r: got %b want 01", m_rvalid); end
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        m_arlen[15:8] = 8'd7; m_arvalid = 2'b10; m_rready = 2'b10;
        step();
        n_cmp++; if (m_arready !== 2'b10) begin n_mis++; $display("FAIL rm_ar1: got %b want 10", m_arready); end
        step();
        m_arvalid = 2'b00; s_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rdata = 32'(i);
            step();
        end
        s_rdata = 32'd3;
        areset = 1'b1;
        step();
        areset = 1'b0;
        #1;
        n_cmp++; if ({m_rvalid, s_rready, s_arvalid, s_awvalid, s_wvalid} !== 5'b0) begin n_mis++; $display("FAIL rm_after_reset: got %b want 00000", {m_rvalid, s_rready, s_arvalid, s_awvalid, s_wvalid}); end
        s_rvalid = 1'b0;
        m_arvalid = 2'b11;
        step();
        n_cmp++; if (m_arready !== 2'b01) begin n_mis++; $display("FAIL rm_rptr0: got %b want 01", m_arready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_rr_fairness();
        test_concurrent();
        test_grant_hold();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
Round-robin arbiter that shares one AXI slave port between NUM_M AXI master ports, using the project's ID-less AXI channel set (aw, w, b, ar, r with user sidebands).
Write and read paths have independent arbiters, so one master may write while another reads.
Without IDs, a write grant is held until the B handshake completes, and a read grant is held until the R beat with rlast completes.
The block sits between the testbench master agents and the slave agent or DUT.

Parameters:
NUM_M, 2, number of master ports (2..8)
ADDR_WIDTH, 10, address width
DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8
USER_WIDTH, 1, wuser/buser/ruser width

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
m_awaddr/m_awlen/m_awvalid  in  NUM_M*ADDR_WIDTH / NUM_M*8 / NUM_M  per-master AW, packed, master i at slice i
m_awready  out  NUM_M  per-master AW ready
m_wdata/m_wstrb/m_wlast/m_wuser/m_wvalid  in  NUM_M*(DATA_WIDTH, DATA_WIDTH/8, 1, USER_WIDTH, 1)  per-master W
m_wready  out  NUM_M  per-master W ready
m_bresp/m_buser/m_bvalid  out  NUM_M*(2, USER_WIDTH, 1)  per-master B
m_bready  in  NUM_M  per-master B ready
m_araddr/m_arlen/m_arvalid  in  NUM_M*(ADDR_WIDTH, 8, 1)  per-master AR
m_arready  out  NUM_M  per-master AR ready
m_rdata/m_rlast/m_ruser/m_rresp/m_rvalid  out  NUM_M*(DATA_WIDTH, 1, USER_WIDTH, 2, 1)  per-master R
m_rready  in  NUM_M  per-master R ready
s_aw*/s_w*/s_ar*  out  single-port widths  slave-side request channels
s_awready/s_wready/s_arready  in  1  slave-side ready
s_b*/s_r*  in  single-port widths  slave-side response channels
s_bready/s_rready  out  1  slave-side response ready

Behaviour:
- Reset (areset=1 at a clock edge):
  - Both FSMs go to IDLE.
  - Both round-robin pointers are set to 0.
  - Grants are cleared.
  - All s_*valid, s_bready, s_rready, m_*ready and m_*valid outputs are 0.
  - Data and address outputs are don't-care but are driven 0.
- Reset mid-burst aborts the transaction immediately; no completion is issued.
- Write FSM:
  - W_IDLE:
    - If any m_awvalid is set, pick the first requester at or after wptr, searching cyclically.
    - Register wgnt and go to W_ADDR.
    - Nothing is forwarded in W_IDLE, so the AW grant latency is 1 cycle.
  - W_ADDR:
    - s_aw* = m_aw*[wgnt] and m_awready[wgnt] = s_awready; all other ready signals are 0.
    - On an s_awvalid & s_awready handshake, go to W_DATA.
  - W_DATA:
    - s_w* = m_w*[wgnt] and m_wready[wgnt] = s_wready.
    - On a handshake with wlast=1, go to W_RESP.
    - The arbiter does not count beats; wlast alone ends the burst.
  - W_RESP:
    - m_b*[wgnt] = s_b* and s_bready = m_bready[wgnt]; m_bvalid of other masters is 0.
    - On the B handshake, go to W_IDLE and set wptr = (wgnt+1) mod NUM_M.
- W data presented before AW is accepted is not forwarded: wready stays 0 until W_DATA. This is legal AXI.
- Read FSM:
  - R_IDLE: selects rgnt using rptr in the same way, with 1-cycle latency.
  - R_ADDR: forwards AR.
  - R_DATA: forwards R to master rgnt.
  - Exit R_DATA to R_IDLE on an R handshake with rlast=1, then set rptr = (rgnt+1) mod NUM_M.
- Write and read FSMs are fully independent. The same master may hold both grants at once.
- All forwarding is combinational from the registered grant. The arbiter adds no data latency after the grant.
- s_*valid is never asserted outside the matching state.
- A request withdrawn before grant (illegal AXI) is ignored. If no request remains, W_IDLE does nothing.

Test Plan:
- Single master write: m0 sends awaddr=0x040, awlen=3, data 0..3. Required: s_awvalid rises 1 cycle after m_awvalid, 4 beats pass in order, m_bvalid[0] is set with bresp=0, m_bvalid[1]=0, wptr=1.
- Simultaneous AW from m0 and m1 after reset, awlen=0 each. Required: m0 is served first through B, then m1. Repeating gives the order m0,m1,m0,m1 (round-robin fairness).
- Concurrent paths: m1 reads (araddr=0x100, arlen=7) while m0 writes (awlen=1). Required: both complete with no stall between paths, m1 receives 8 beats with rlast on the 8th, and m0 receives no R valid.
- Grant hold: m0 is in W_DATA with wlast not yet seen and m1 asserts awvalid. Required: m_awready[1]=0 until m0's B handshake completes.
- Back-pressure: s_wready toggles 1010 and m_bready[0] is held 0 for 5 cycles. Required: the FSM stays in W_RESP with s_bready=0 and no data is lost.
- Reset during R_DATA beat 3 of 8. Required: the next cycle has all valids 0, the FSM is in R_IDLE, and rptr=0.
